lzw_dict_search: RTL and testbench

Dictionary sequencer for the LZW compression datapath. For each (prefix, symbol) pair handed over by the microprogrammed controller it drives a linear scan of the dictionary RAM, reports hit/miss and the matching code, and appends the pair as a new entry on a miss. It is the single master of the dictionary RAM port. Its `found` and `full` outputs feed the controller's jump conditions.

---
 rtl/lzw_dict_search.sv | 234 +++++++++++++++++++++++
 tb/tb_lzw_dict_search.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzw_dict_search.sv
// LZW dictionary sequencer: linear scan of the dictionary RAM with append-on-miss.
// Optional one-entry last-result cache is built when LZW_LAST_HIT_EN is defined.
module lzw_dict_search #(
   parameter int CODE_W     = 12,
   parameter int SYM_W      = 8,
   parameter int FIRST_CODE = 256
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     no_prefix,
   input  logic [CODE_W-1:0]        prefix,
   input  logic [SYM_W-1:0]         symbol,
   input  logic                     clear,
   output logic                     busy,
   output logic                     done,
   output logic                     found,
   output logic [CODE_W-1:0]        code_out,
   output logic                     full,
   output logic [CODE_W-1:0]        ram_addr,
   output logic [CODE_W+SYM_W-1:0]  ram_wdata,
   output logic                     ram_we,
   input  logic [CODE_W+SYM_W-1:0]  ram_rdata
);

   localparam int PTR_W = CODE_W + 1;
   localparam int Q_W   = CODE_W + SYM_W;
   localparam logic [PTR_W-1:0] FIRST_PTR = PTR_W'(FIRST_CODE);
   localparam logic [PTR_W-1:0] FULL_PTR  = {1'b1, {CODE_W{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_READ   = 3'd1,
      S_CMP    = 3'd2,
      S_INSERT = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  ins_ptr_q, ins_ptr_d;
   logic [PTR_W-1:0]  sp_q, sp_d;
   logic [Q_W-1:0]    query_q, query_d;
   logic              found_q, found_d;
   logic [CODE_W-1:0] code_q, code_d;

   logic [Q_W-1:0]    query_in;
   logic [CODE_W-1:0] lit_code;
   logic              empty;
   logic              is_full;
   logic              rd_match;
   logic              scan_more;
   logic              cache_hit;
   logic [CODE_W-1:0] cache_code;

   assign query_in  = {prefix, symbol};
   assign lit_code  = CODE_W'(symbol);
   assign empty     = (ins_ptr_q == FIRST_PTR);
   assign is_full   = (ins_ptr_q == FULL_PTR);
   assign rd_match  = (ram_rdata == query_q);
   // sp+1 is evaluated at pointer width so the last entry of a full table compares correctly
   assign scan_more = ((sp_q + PTR_W'(1)) < ins_ptr_q);

`ifdef LZW_LAST_HIT_EN
   logic              cache_valid_q, cache_valid_d;
   logic [Q_W-1:0]    cache_key_q, cache_key_d;
   logic [CODE_W-1:0] cache_code_q, cache_code_d;

   assign cache_hit  = cache_valid_q && (cache_key_q == query_in);
   assign cache_code = cache_code_q;

   always_comb begin
      cache_valid_d = cache_valid_q;
      cache_key_d   = cache_key_q;
      cache_code_d  = cache_code_q;
      if (state_q == S_IDLE && clear) begin
         cache_valid_d = 1'b0;
      end else if (state_q == S_CMP && rd_match) begin
         cache_valid_d = 1'b1;
         cache_key_d   = query_q;
         cache_code_d  = sp_q[CODE_W-1:0];
      end else if (state_q == S_INSERT) begin
         cache_valid_d = 1'b1;
         cache_key_d   = query_q;
         cache_code_d  = ins_ptr_q[CODE_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cache_valid_q <= 1'b0;
         cache_key_q   <= '0;
         cache_code_q  <= '0;
      end else begin
         cache_valid_q <= cache_valid_d;
         cache_key_q   <= cache_key_d;
         cache_code_q  <= cache_code_d;
      end
   end
`else
   assign cache_hit  = 1'b0;
   assign cache_code = '0;
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; clear in IDLE wins over start
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (!clear && start) begin
               if (no_prefix || cache_hit) begin
                  state_d = S_DONE;
               end else if (!empty) begin
                  state_d = S_READ;
               end else if (is_full) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_INSERT;
               end
            end
         end
         S_READ:   state_d = S_CMP;
         S_CMP: begin
            if (rd_match) begin
               state_d = S_DONE;
            end else if (scan_more) begin
               state_d = S_READ;
            end else if (is_full) begin
               state_d = S_DONE;
            end else begin
               state_d = S_INSERT;
            end
         end
         S_INSERT: state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath next values; the result registers only change on the way into DONE
   always_comb begin
      ins_ptr_d = ins_ptr_q;
      sp_d      = sp_q;
      query_d   = query_q;
      found_d   = found_q;
      code_d    = code_q;
      case (state_q)
         S_IDLE: begin
            if (clear) begin
               ins_ptr_d = FIRST_PTR;
            end else if (start) begin
               query_d = query_in;
               sp_d    = FIRST_PTR;
               if (no_prefix) begin
                  found_d = 1'b1;
                  code_d  = lit_code;
               end else if (cache_hit) begin
                  found_d = 1'b1;
                  code_d  = cache_code;
               end else if (empty && is_full) begin
                  found_d = 1'b0;
                  code_d  = '0;
               end
            end
         end
         S_CMP: begin
            if (rd_match) begin
               found_d = 1'b1;
               code_d  = sp_q[CODE_W-1:0];
            end else if (scan_more) begin
               sp_d = sp_q + PTR_W'(1);
            end else if (is_full) begin
               found_d = 1'b0;
               code_d  = '0;
            end
         end
         S_INSERT: begin
            found_d   = 1'b0;
            code_d    = ins_ptr_q[CODE_W-1:0];
            ins_ptr_d = ins_ptr_q + PTR_W'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ins_ptr_q <= FIRST_PTR;
         sp_q      <= FIRST_PTR;
         query_q   <= '0;
         found_q   <= 1'b0;
         code_q    <= '0;
      end else begin
         ins_ptr_q <= ins_ptr_d;
         sp_q      <= sp_d;
         query_q   <= query_d;
         found_q   <= found_d;
         code_q    <= code_d;
      end
   end

   // Output decode; the RAM port is idle (all zero) outside READ and INSERT
   always_comb begin
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      case (state_q)
         S_READ: begin
            ram_addr = sp_q[CODE_W-1:0];
         end
         S_INSERT: begin
            ram_we    = 1'b1;
            ram_addr  = ins_ptr_q[CODE_W-1:0];
            ram_wdata = query_q;
         end
         default: ;
      endcase
   end

   assign found    = found_q;
   assign code_out = code_q;
   assign full     = is_full;

endmodule

// File: tb/tb_lzw_dict_search.sv
// Bench for lzw_dict_search: behavioural dictionary model (queue of stored pairs) plus a RAM model.
// A small 9-bit code space with a high first code keeps the fill scenario short.
module tb_lzw_dict_search;

   localparam int CODE_W     = 9;
   localparam int SYM_W      = 8;
   localparam int FIRST_CODE = 448;
   localparam int CAP        = (1 << CODE_W) - FIRST_CODE;
   localparam int Q_W        = CODE_W + SYM_W;
   localparam int BUDGET     = 2 * CAP + 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              no_prefix;
   logic [CODE_W-1:0] prefix;
   logic [SYM_W-1:0]  symbol;
   logic              clear;
   logic              busy;
   logic              done;
   logic              found;
   logic [CODE_W-1:0] code_out;
   logic              full;
   logic [CODE_W-1:0] ram_addr;
   logic [Q_W-1:0]    ram_wdata;
   logic              ram_we;
   logic [Q_W-1:0]    ram_rdata;

   logic [Q_W-1:0]    mem [1 << CODE_W];

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: stored pairs in insertion order; entry i has code FIRST_CODE+i
   logic [Q_W-1:0]    dict_q[$];
   bit                cache_valid = 1'b0;
   logic [Q_W-1:0]    cache_key   = '0;
   logic [CODE_W-1:0] cache_code  = '0;

   lzw_dict_search #(
      .CODE_W(CODE_W),
      .SYM_W(SYM_W),
      .FIRST_CODE(FIRST_CODE)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .no_prefix(no_prefix),
      .prefix(prefix),
      .symbol(symbol),
      .clear(clear),
      .busy(busy),
      .done(done),
      .found(found),
      .code_out(code_out),
      .full(full),
      .ram_addr(ram_addr),
      .ram_wdata(ram_wdata),
      .ram_we(ram_we),
      .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   task automatic model_empty();
      dict_q.delete();
      cache_valid = 1'b0;
   endtask

   task automatic lookup(input string tag, input bit np,
                         input logic [CODE_W-1:0] pre, input logic [SYM_W-1:0] sym);
      logic [Q_W-1:0]    key;
      int                k;
      int                n;
      bit                chit;
      bit                exp_found;
      logic [CODE_W-1:0] exp_code;
      int                exp_done;
      int                exp_we;
      bit                exp_full;
      int                we_seen;
      int                done_seen;
      logic [CODE_W-1:0] we_addr;
      logic [Q_W-1:0]    we_data;
      logic              got_found;
      logic [CODE_W-1:0] got_code;
      logic              got_full;
      bit                busy_ok;

      key  = {pre, sym};
      n    = dict_q.size();
      k    = -1;
      for (int i = 0; i < n; i++) if (k < 0 && dict_q[i] == key) k = i;
      chit = !np && cache_valid && (cache_key == key);
      exp_we = -1;
      if (np) begin
         exp_found = 1'b1; exp_code = CODE_W'(sym); exp_done = 1;
      end else if (chit) begin
         exp_found = 1'b1; exp_code = cache_code; exp_done = 1;
      end else if (k >= 0) begin
         exp_found = 1'b1; exp_code = CODE_W'(FIRST_CODE + k); exp_done = 3 + 2 * k;
      end else if (n == CAP) begin
         exp_found = 1'b0; exp_code = '0; exp_done = 2 * n + 1;
      end else begin
         exp_found = 1'b0; exp_code = CODE_W'(FIRST_CODE + n);
         exp_we = 2 * n + 1; exp_done = 2 * n + 2;
      end
      exp_full = ((!np && !chit && k < 0 && n < CAP) ? n + 1 : n) == CAP;

      @(negedge clk);
      start = 1'b1; no_prefix = np; prefix = pre; symbol = sym;
      @(posedge clk); #1;
      start = 1'b0; no_prefix = 1'b0;
      we_seen = -1; done_seen = -1; busy_ok = 1'b1;
      we_addr = '0; we_data = '0; got_found = 1'bx; got_code = 'x; got_full = 1'bx;
      for (int c = 1; c <= BUDGET; c++) begin
         if (ram_we && we_seen < 0) begin
            we_seen = c; we_addr = ram_addr; we_data = ram_wdata;
         end
         if (!busy) busy_ok = 1'b0;
         if (done) begin
            done_seen = c; got_found = found; got_code = code_out; got_full = full;
            break;
         end
         @(posedge clk); #1;
      end

      n_cmp++; if (done_seen !== exp_done) begin n_fail++;
         $display("FAIL %s done_cycle: got %0d want %0d", tag, done_seen, exp_done); end
      n_cmp++; if (got_found !== exp_found) begin n_fail++;
         $display("FAIL %s found: got %b want %b", tag, got_found, exp_found); end
      n_cmp++; if (got_code !== exp_code) begin n_fail++;
         $display("FAIL %s code_out: got 0x%0h want 0x%0h", tag, got_code, exp_code); end
      n_cmp++; if (we_seen !== exp_we) begin n_fail++;
         $display("FAIL %s ram_we_cycle: got %0d want %0d", tag, we_seen, exp_we); end
      if (exp_we >= 0) begin
         n_cmp++; if (we_addr !== CODE_W'(FIRST_CODE + n)) begin n_fail++;
            $display("FAIL %s ram_addr: got 0x%0h want 0x%0h", tag, we_addr, FIRST_CODE + n); end
         n_cmp++; if (we_data !== key) begin n_fail++;
            $display("FAIL %s ram_wdata: got 0x%0h want 0x%0h", tag, we_data, key); end
      end
      n_cmp++; if (busy_ok !== 1'b1) begin n_fail++;
         $display("FAIL %s busy_during: got %b want 1", tag, busy_ok); end
      n_cmp++; if (got_full !== exp_full) begin n_fail++;
         $display("FAIL %s full: got %b want %b", tag, got_full, exp_full); end

      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++;
         $display("FAIL %s after_done busy/done: got %b/%b want 0/0", tag, busy, done); end

      if (!np && !chit) begin
         if (k >= 0) begin
            cache_key = key; cache_code = CODE_W'(FIRST_CODE + k);
         end else if (n < CAP) begin
            dict_q.push_back(key);
            cache_key = key; cache_code = CODE_W'(FIRST_CODE + n);
         end
`ifdef LZW_LAST_HIT_EN
         if (k >= 0 || n < CAP) cache_valid = 1'b1;
`endif
      end
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      model_empty();
      n_cmp++; if (busy !== 1'b0) begin n_fail++;
         $display("FAIL clear busy: got %b want 0", busy); end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; clear = 1'b0; no_prefix = 1'b0;
      prefix = '0; symbol = '0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if ({busy, done, found, full, ram_we} !== 5'b0) begin n_fail++;
         $display("FAIL reset flags: got %b want 00000", {busy, done, found, full, ram_we}); end
      n_cmp++; if (code_out !== '0) begin n_fail++;
         $display("FAIL reset code_out: got 0x%0h want 0", code_out); end
      n_cmp++; if (ram_addr !== '0 || ram_wdata !== '0) begin n_fail++;
         $display("FAIL reset ram_port: got 0x%0h/0x%0h want 0/0", ram_addr, ram_wdata); end
      @(negedge clk);
      reset = 1'b0;
      model_empty();
   endtask

   task automatic test_literal();
      lookup("literal_41", 1'b1, '0, 8'h41);
      n_cmp++; if (code_out !== 9'h041) begin n_fail++;
         $display("FAIL literal_41 held_code: got 0x%0h want 0x041", code_out); end
   endtask

   task automatic test_first_insert();
      lookup("first_insert", 1'b0, 9'h041, 8'h42);
   endtask

   task automatic test_hit();
      lookup("ins_2", 1'b0, 9'h043, 8'h44);
      lookup("ins_3", 1'b0, 9'h045, 8'h46);
      lookup("hit_3", 1'b0, 9'h045, 8'h46);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         bit np;
         np = ($urandom_range(0, 5) == 0);
         lookup("random", np, CODE_W'($urandom_range(9'h041, 9'h044)),
                SYM_W'($urandom_range(8'h41, 8'h44)));
      end
   endtask

   task automatic test_clear_start();
      bit quiet;
      @(negedge clk);
      clear = 1'b1; start = 1'b1; no_prefix = 1'b0; prefix = 9'h041; symbol = 8'h42;
      @(posedge clk); #1;
      clear = 1'b0; start = 1'b0;
      model_empty();
      quiet = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (busy || done || ram_we) quiet = 1'b0;
         @(posedge clk); #1;
      end
      n_cmp++; if (quiet !== 1'b1) begin n_fail++;
         $display("FAIL clear_start quiet: got %b want 1", quiet); end
      lookup("after_clear", 1'b0, 9'h041, 8'h42);
      lookup("after_clear2", 1'b0, 9'h041, 8'h43);
   endtask

   task automatic test_fill();
      logic [Q_W-1:0] e;
      do_clear();
      for (int i = 0; i < CAP; i++) begin
         lookup("fill", 1'b0, CODE_W'(i), SYM_W'($urandom_range(0, 255)));
      end
      n_cmp++; if (full !== 1'b1) begin n_fail++;
         $display("FAIL fill full_level: got %b want 1", full); end
      lookup("full_miss", 1'b0, 9'h1FF, 8'h00);
      e = dict_q[10];
      lookup("full_hit", 1'b0, e[Q_W-1:SYM_W], e[SYM_W-1:0]);
      e = dict_q[CAP-1];
      lookup("full_hit_last", 1'b0, e[Q_W-1:SYM_W], e[SYM_W-1:0]);
   endtask

   task automatic test_reset_insert();
      do_clear();
      @(negedge clk);
      start = 1'b1; no_prefix = 1'b0; prefix = 9'h055; symbol = 8'h66;
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++; if (ram_we !== 1'b1) begin n_fail++;
         $display("FAIL rst_ins in_insert ram_we: got %b want 1", ram_we); end
      reset = 1'b1;
      #1;
      n_cmp++; if ({busy, done, found, ram_we, full} !== 5'b0) begin n_fail++;
         $display("FAIL rst_ins flags: got %b want 00000", {busy, done, found, ram_we, full}); end
      n_cmp++; if (code_out !== '0 || ram_addr !== '0 || ram_wdata !== '0) begin n_fail++;
         $display("FAIL rst_ins values: got 0x%0h/0x%0h/0x%0h want 0/0/0",
                  code_out, ram_addr, ram_wdata); end
      @(negedge clk);
      reset = 1'b0;
      model_empty();
      lookup("rst_ins_retry", 1'b0, 9'h055, 8'h66);
      lookup("rst_ins_second", 1'b0, 9'h055, 8'h67);
      lookup("rst_ins_hit", 1'b0, 9'h055, 8'h66);
   endtask

   initial begin
      test_reset();
      test_literal();
      test_first_insert();
      test_hit();
      test_random();
      test_clear_start();
      test_fill();
      test_reset_insert();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
